// File: rtl/seq_booth_mult.sv
// seq_booth_mult: radix-2 Booth sequential multiplier, signed/unsigned, start/busy/done handshake
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] previous_product
);
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH+1:0]   a_q, a_d, sum;
  logic [WIDTH:0]     mx_q, mx_d, qx_q, qx_d;
  logic               qm1_q, qm1_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prev_q, prev_d;
  always_comb begin
    sum = ({qx_q[0], qm1_q} == 2'b01) ? a_q + {mx_q[WIDTH], mx_q} :
          ({qx_q[0], qm1_q} == 2'b10) ? a_q - {mx_q[WIDTH], mx_q} : a_q;
    state_d = state_q;
    a_d     = a_q;
    mx_d    = mx_q;
    qx_d    = qx_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    prev_d  = prev_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      mx_d    = {is_signed & multiplicand[WIDTH-1], multiplicand};
      qx_d    = {is_signed & multiplier[WIDTH-1], multiplier};
      a_d     = '0;
      qm1_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      {a_d, qx_d, qm1_d} = {sum[WIDTH+1], sum, qx_q};
      cnt_d = cnt_q + 1'b1;
      // the last iteration's shifted result is captured directly into product
      if (cnt_q == CW'(WIDTH)) begin
        state_d = DONE;
        prev_d  = prod_q;
        prod_d  = {sum[WIDTH-1:0], qx_q[WIDTH:1]};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      mx_q    <= '0;
      qx_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mx_q    <= mx_d;
      qx_q    <= qx_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      prev_q  <= prev_d;
    end
  end
  assign busy             = busy_q;
  assign done             = done_q;
  assign product          = prod_q;
  assign previous_product = prev_q;
endmodule

// File: tb/tb_seq_booth_mult.sv
// tb_seq_booth_mult: WIDTH=8 and WIDTH=16 multipliers checked every cycle against a timeline/arithmetic model
module tb_seq_booth_mult;
  logic clk = 0;
  logic rst = 0;
  logic        st[2] = '{0, 0};
  logic        sg[2] = '{0, 0};
  logic [15:0] mc[2] = '{0, 0};
  logic [15:0] mp[2] = '{0, 0};
  logic        busy_o[2], done_o[2];
  logic [31:0] prod_o[2], prev_o[2];
  logic [15:0] p8, v8;
  logic [31:0] p16, v16;
  int tests = 0, fails = 0;
  int          ph[2] = '{0, 0};
  logic [31:0] pend[2] = '{0, 0};
  logic [31:0] mprod[2] = '{0, 0};
  logic [31:0] mprev[2] = '{0, 0};

  always #5 clk = ~clk;

  seq_booth_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st[0]), .is_signed(sg[0]),
    .multiplicand(mc[0][7:0]), .multiplier(mp[0][7:0]),
    .busy(busy_o[0]), .done(done_o[0]), .product(p8), .previous_product(v8));
  seq_booth_mult #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st[1]), .is_signed(sg[1]),
    .multiplicand(mc[1]), .multiplier(mp[1]),
    .busy(busy_o[1]), .done(done_o[1]), .product(p16), .previous_product(v16));
  assign prod_o[0] = {16'h0, p8};
  assign prev_o[0] = {16'h0, v8};
  assign prod_o[1] = p16;
  assign prev_o[1] = v16;

  function automatic int wd(int i);
    return i ? 16 : 8;
  endfunction

  // plain integer arithmetic, truncated to 2*w bits
  function automatic logic [31:0] ref_mul(int w, logic s, logic [15:0] a, logic [15:0] b);
    longint m = (longint'(1) << w) - 1;
    longint x = longint'(a) & m;
    longint y = longint'(b) & m;
    if (s && x[w-1]) x -= (longint'(1) << w);
    if (s && y[w-1]) y -= (longint'(1) << w);
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: accept when idle, busy for w+1 cycles, done for one, then idle
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] <= 0; mprod[i] <= 0; mprev[i] <= 0;
      end else if (ph[i] == 0) begin
        if (st[i]) begin
          ph[i] <= 1;
          pend[i] <= ref_mul(wd(i), sg[i], mc[i], mp[i]);
        end
      end else if (ph[i] == wd(i) + 2) begin
        ph[i] <= 0;
      end else begin
        ph[i] <= ph[i] + 1;
        if (ph[i] == wd(i) + 1) begin
          mprev[i] <= mprod[i];
          mprod[i] <= pend[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy%0d", wd(i)), 32'(busy_o[i]), 32'(ph[i] >= 1 && ph[i] <= wd(i) + 1));
        chk($sformatf("done%0d", wd(i)), 32'(done_o[i]), 32'(ph[i] == wd(i) + 2));
        chk($sformatf("product%0d", wd(i)), prod_o[i], mprod[i]);
        chk($sformatf("prev%0d", wd(i)), prev_o[i], mprev[i]);
        if (busy_o[i] && done_o[i]) chk("busy_and_done", 1, 0);
      end
    end
  end

  task automatic wait_idle(int i);
    int n = 0;
    @(negedge clk);
    while (ph[i] != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout", 32'(n), 0);
  endtask

  task automatic op(int i, logic s, logic [15:0] a, logic [15:0] b,
                    output logic [31:0] p, output int lat);
    int n = 0;
    wait_idle(i);
    st[i] = 1; sg[i] = s; mc[i] = a; mp[i] = b;
    @(posedge clk); #1 st[i] = 0;
    mc[i] = ~a; mp[i] = ~b; sg[i] = ~s;
    do begin @(negedge clk); n++; end while (!done_o[i] && n < 100);
    if (n >= 100) chk("done_timeout", 32'(n), 0);
    lat = n;
    p = prod_o[i];
  endtask

  function automatic logic [15:0] pick(int w);
    logic [15:0] msk = 16'((32'h1 << w) - 1);
    case ($urandom_range(0, 7))
      0: return 16'h0;
      1: return 16'h1;
      2: return msk;
      3: return 16'(32'h1 << (w - 1));
      4: return msk >> 1;
      default: return 16'($urandom) & msk;
    endcase
  endfunction

  initial begin
    logic [31:0] p, last;
    logic [15:0] a, b;
    int lat, nd, nb;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_done", 32'(done_o[0]), 0);
    chk("rst_product", prod_o[0], 0);
    chk("rst_prev", prev_o[1], 0);
    rst = 0;
    chk("model_pin1", ref_mul(8, 1, 16'h7, 16'hFD), 32'hFFEB);
    chk("model_pin2", ref_mul(8, 0, 16'hFF, 16'hFF), 32'hFE01);
    op(0, 1, 16'h7, 16'hFD, p, lat);
    chk("7xm3", p, 32'hFFEB);
    chk("latency", 32'(lat), 10);
    op(0, 1, 16'h80, 16'h80, p, lat);
    chk("min_x_min", p, 32'h4000);
    op(0, 1, 16'h80, 16'h7F, p, lat);
    chk("min_x_max", p, 32'hC080);
    chk("min_x_max_prev", prev_o[0], 32'h4000);
    op(0, 0, 16'hFF, 16'hFF, p, lat);
    chk("ff_unsigned", p, 32'hFE01);
    op(0, 1, 16'hFF, 16'hFF, p, lat);
    chk("ff_signed", p, 32'h0001);
    // restarts mid-operation must be ignored
    wait_idle(0);
    st[0] = 1; sg[0] = 0; mc[0] = 25; mp[0] = 3;
    nd = 0; nb = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 0 || n == 3 || n == 6) st[0] = 0;
      if (n == 2 || n == 5) begin st[0] = 1; mc[0] = 99; mp[0] = 77; end
      nb += busy_o[0];
      nd += done_o[0];
    end
    chk("ignored_done_count", 32'(nd), 1);
    chk("ignored_busy_len", 32'(nb), 9);
    chk("ignored_product", prod_o[0], 32'h004B);
    // asynchronous reset in RUN aborts everything
    wait_idle(0);
    st[0] = 1; sg[0] = 1; mc[0] = 16'h7F; mp[0] = 16'h33;
    @(posedge clk); #1 st[0] = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_o[0]), 0);
    chk("abort_done", 32'(done_o[0]), 0);
    chk("abort_product", prod_o[0], 0);
    chk("abort_prev", prev_o[0], 0);
    rst = 0;
    op(0, 0, 16'd12, 16'd12, p, lat);
    chk("12x12", p, 32'h0090);
    chk("12x12_latency", 32'(lat), 10);
    // start held high: back-to-back operations every WIDTH+3 cycles
    wait_idle(0);
    st[0] = 1; sg[0] = 1; mc[0] = 5; mp[0] = 6;
    nd = 0;
    for (int n = 0; n < 33; n++) begin @(negedge clk); nd += done_o[0]; end
    st[0] = 0;
    chk("held_start_dones", 32'(nd), 3);
    chk("held_start_product", prod_o[0], 32'h001E);
    for (int i = 0; i < 2; i++) begin
      last = prod_o[i];
      for (int n = 0; n < 40; n++) begin
        a = pick(wd(i)); b = pick(wd(i));
        op(i, n[0], a, b, p, lat);
        chk($sformatf("sweep%0d", wd(i)), p, ref_mul(wd(i), n[0], a, b));
        chk($sformatf("sweep_prev%0d", wd(i)), prev_o[i], last);
        last = p;
      end
    end
    wait_idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Parametrised signed/unsigned sequential multiplier core using radix-2 Booth recoding, with a start/busy/done handshake. It owns the operand, partial-product and previous-result registers, so no separate previous-multiplier register block is needed. It sits between the operand-load logic and the result consumer in the multiplier datapath. Each operation takes WIDTH+1 iteration cycles, and the last two results stay visible.

## Interface
- WIDTH, 8: operand width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- multiplicand  input  WIDTH  operand M; latched with start.
- multiplier  input  WIDTH  operand Q; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is valid in that cycle.
- product  output  2*WIDTH  most recent completed result; held until the next done.
- previous_product  output  2*WIDTH  result before the current product.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when the iteration count reaches WIDTH+1.
  - DONE→IDLE unconditionally.
- Load (IDLE with start):
  - Extend both operands to WIDTH+1 bits: sign-extend if is_signed, zero-extend otherwise. Store the extended multiplicand as Mx.
  - Set A = 0 (WIDTH+2 bits), Qx = extended multiplier, q_m1 = 0, cnt = 0.
- Each RUN cycle, inspect {Qx[0], q_m1}:
  - 01: A = A + Mx, with Mx sign-extended to WIDTH+2.
  - 10: A = A − Mx.
  - 00/11: A unchanged.
  - Then arithmetic-shift {A, Qx, q_m1} right by 1 and increment cnt.
- WIDTH+1 iterations cover the full extended operand, so unsigned and signed modes share one datapath.
- Result = low 2*WIDTH bits of {A, Qx}; it is exact in both modes.
- On entering DONE:
  - previous_product ← product.
  - product ← result.
  - done = 1 for that cycle only.
- start while busy, or in DONE, is ignored; there is no queuing.
- Operand inputs may change freely after the start cycle.
- Internal registers are not cleared on done; only product and previous_product are architecturally visible.

## Timing
- start sampled high at edge k in IDLE:
  - busy = 1 for cycles k+1 … k+WIDTH+1.
  - done = 1 and the new product are visible in cycle k+WIDTH+2.
  - Back in IDLE at k+WIDTH+3.
- Latency is WIDTH+2 cycles from start to done. Maximum throughput is one operation per WIDTH+3 cycles.
- busy and done are never high together.
- Reset values: state IDLE; busy = 0, done = 0, product = 0, previous_product = 0; A, Qx, q_m1, cnt cleared.
- Reset asserted mid-operation aborts it. No done is emitted, and product and previous_product both return to 0.
- The first start after reset deasserts follows normal timing.
- start held high continuously: a new operation starts each time the FSM re-enters IDLE, i.e. every WIDTH+3 cycles.
- cnt width is $clog2(WIDTH+2); cnt never wraps within an operation.

## Test plan
- WIDTH=8, is_signed=1, multiplicand 8'd7, multiplier 8'hFD (−3) → done exactly 10 cycles after start, product 16'hFFEB (−21).
- is_signed=1, both operands 8'h80 (−128) → product 16'h4000. Then 8'h80 × 8'h7F → 16'hC080, with previous_product 16'h4000.
- is_signed=0, 8'hFF × 8'hFF → product 16'hFE01. The same operands with is_signed=1 → 16'h0001.
- start pulsed again on cycles 3 and 6 of RUN with different operands → ignored: a single done, product from the first operands, busy duration unchanged.
- rst asserted on cycle 5 of RUN → busy, done, product and previous_product are 0 in the next sampled cycle, with no done pulse. A new 8'd12 × 8'd12 then yields 16'h0090.
- Randomised WIDTH=8 and WIDTH=16 sweeps in both modes against a reference model. Covers zeros, ±1, min, max and start held high; every result must match, and previous_product must track the prior result.
